alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq_mul.sv | 67 ++++++
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the registered, handshaked ALU.
//   op_mne      - opcode mnemonics (5-bit encoding), including SUB, SHLV,
//                 SHRV and MUL.
//   alu_state_t - FSM state type, with IDLE/BUSY/DONE state constants.
// Optional feature macro used by the ALU: ALU_MUL_EN.
package alu_seq_pkg;

  localparam int OPS_W = 5;

  typedef enum logic [OPS_W-1:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    CMP    = 5'd2,
    CMP_LS = 5'd3,
    AND    = 5'd4,
    ORR    = 5'd5,
    XOR_B  = 5'd6,
    XOR_G  = 5'd7,
    SHL    = 5'd8,
    SHR    = 5'd9,
    SHLV   = 5'd10,
    SHRV   = 5'd11,
    MUL    = 5'd12
  } op_mne;

  typedef logic [1:0] alu_state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//   master modport: producer/consumer side (drives operands, OutReady).
//   slave modport : ALU side (drives InReady, result and flags).
// Signals: InValid/InReady, InputA, InputB, OP, OutValid/OutReady,
//          Out, Zero, Carry, Err.
interface alu_seq_if #(
  parameter int W   = 8,
  parameter int Ops = 5
);
  logic           InValid;
  logic           InReady;
  logic [W-1:0]   InputA;
  logic [W-1:0]   InputB;
  logic [Ops-1:0] OP;
  logic           OutValid;
  logic           OutReady;
  logic [W-1:0]   Out;
  logic           Zero;
  logic           Carry;
  logic           Err;

  modport master (
    output InValid, InputA, InputB, OP, OutReady,
    input  InReady, OutValid, Out, Zero, Carry, Err
  );

  modport slave (
    input  InValid, InputA, InputB, OP, OutReady,
    output InReady, OutValid, Out, Zero, Carry, Err
  );
endinterface

// File: rtl/alu_seq_mul.sv
// shift_add_mul: iterative unsigned W x W multiplier, one multiplier bit
// per cycle.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (aborts a product)
//   i_start   - load operands and begin (ignored rows: none, restarts)
//   i_a, i_b  - multiplicand, multiplier
//   o_done    - one-cycle pulse once the W-th iteration has completed
//   o_prod    - 2W-bit product, valid while o_done is high
module shift_add_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_prod
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic           r_busy;
  logic           r_done;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;

  // Control: busy/done/counter are reset so an aborted product never
  // produces a late done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(W-1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Datapath: shift-and-add, LSB of the multiplier first.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU with carry and error flags.
// Single-cycle ops land in DONE the cycle after accept; MUL (only when the
// ALU_MUL_EN macro is defined) runs through the iterative shift_add_mul and
// completes W+1 cycles after accept. Without ALU_MUL_EN, MUL is illegal.
// Ports:
//   Clk   - rising-edge clock
//   Reset - synchronous, active-high reset
//   bus   - alu_seq_if.slave: InValid/InReady, InputA, InputB, OP,
//           OutValid/OutReady, Out, Zero, Carry, Err
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int Ops = 5,
  parameter int SW  = $clog2(W)
) (
  input  logic      Clk,
  input  logic      Reset,
  alu_seq_if.slave  bus
);

  alu_state_t     r_state;
  logic [W-1:0]   r_out;
  logic           r_zero;
  logic           r_carry;
  logic           r_err;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_is_mul;
  logic [W-1:0]   w_res;
  logic           w_carry;
  logic           w_err;
  logic [SW-1:0]  w_amt;
  logic           w_mul_done;
  logic [2*W-1:0] w_mul_prod;

  // The only combinational input-to-output path: a held result may be
  // retired and replaced in the same cycle.
  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.OutReady);
  assign w_accept   = bus.InValid && w_in_ready;
  assign w_amt      = bus.InputB[SW-1:0];

`ifdef ALU_MUL_EN
  assign w_is_mul = (bus.OP == Ops'(MUL));

  shift_add_mul #(.W(W)) u_mul (
    .clk     (Clk),
    .rst     (Reset),
    .i_start (w_accept && w_is_mul),
    .i_a     (bus.InputA),
    .i_b     (bus.InputB),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  // Single-cycle result, computed from the live operands and captured only
  // on accept.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (bus.OP)
      Ops'(ADD):    {w_carry, w_res} = {1'b0, bus.InputA} + {1'b0, bus.InputB};
      // Bit W of the widened difference is the borrow.
      Ops'(SUB):    {w_carry, w_res} = {1'b0, bus.InputA} - {1'b0, bus.InputB};
      Ops'(CMP):    w_res = {{(W-1){1'b0}}, (bus.InputA == bus.InputB)};
      Ops'(CMP_LS): w_res = {{(W-1){1'b0}}, (bus.InputA < bus.InputB)};
      Ops'(AND):    w_res = bus.InputA & bus.InputB;
      Ops'(ORR):    w_res = bus.InputA | bus.InputB;
      Ops'(XOR_B):  w_res = bus.InputA ^ bus.InputB;
      Ops'(XOR_G):  w_res = {{(W-1){1'b0}}, ^bus.InputA};
      Ops'(SHL):    {w_carry, w_res} = {bus.InputA, 1'b0};
      Ops'(SHR):    {w_res, w_carry} = {1'b0, bus.InputA};
      // A guard bit beside the operand catches the last bit shifted out;
      // it stays 0 for a zero amount.
      Ops'(SHLV):   {w_carry, w_res} = {1'b0, bus.InputA} << w_amt;
      Ops'(SHRV):   {w_res, w_carry} = {bus.InputA, 1'b0} >> w_amt;
      default:      w_err = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= BUSY;
            end else begin
              r_state <= DONE;
              r_out   <= w_res;
              r_zero  <= ~|w_res;
              r_carry <= w_carry;
              r_err   <= w_err;
            end
          end else if (r_state == DONE && bus.OutReady) begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_mul_done) begin
            r_state <= DONE;
            r_out   <= w_mul_prod[W-1:0];
            r_zero  <= ~|w_mul_prod[W-1:0];
            r_carry <= |w_mul_prod[2*W-1:W];
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = (r_state == DONE);
  assign bus.Out      = r_out;
  assign bus.Zero     = r_zero;
  assign bus.Carry    = r_carry;
  assign bus.Err      = r_err;

`ifdef __ICARUS__
  // Waveform aid: opcode shown as its mnemonic.
  op_mne w_op_mnemonic;
  assign w_op_mnemonic = op_mne'(bus.OP);
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  alu_seq_if #(.W(W), .Ops(5)) u_if ();

  alu_seq #(.W(W), .Ops(5)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an operation for exactly one edge; caller ensures InReady=1.
  task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    u_if.OP      = op;
    u_if.InputA  = a;
    u_if.InputB  = b;
    u_if.InValid = 1'b1;
    @(posedge clk); #1;
    u_if.InValid = 1'b0;
    u_if.InputA  = 8'h5A;
    u_if.InputB  = 8'hC3;
  endtask

  // Single-cycle op with OutReady=1: result must be valid one cycle after
  // accept, then retire.
  task automatic op1(input string tag, input logic [4:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] e_out, input logic e_c,
                     input logic e_err);
    chk({tag, ".rdy"}, u_if.InReady, 1'b1);
    send(op, a, b);
    chk({tag, ".vld"}, u_if.OutValid, 1'b1);
    chk({tag, ".out"}, u_if.Out, e_out);
    chk({tag, ".c"},   u_if.Carry, e_c);
    chk({tag, ".z"},   u_if.Zero, (e_out == 8'h00));
    chk({tag, ".err"}, u_if.Err, e_err);
    @(posedge clk); #1;
    chk({tag, ".idle"}, u_if.OutValid, 1'b0);
  endtask

  initial begin
    int lat;
    n_total = 0;
    n_bad   = 0;
    rst          = 1'b1;
    u_if.InValid = 1'b0;
    u_if.OutReady = 1'b0;
    u_if.OP      = '0;
    u_if.InputA  = '0;
    u_if.InputB  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst.vld", u_if.OutValid, 1'b0);
    chk("rst.rdy", u_if.InReady, 1'b1);
    chk("rst.out", u_if.Out, 8'h00);
    chk("rst.z",   u_if.Zero, 1'b1);
    chk("rst.c",   u_if.Carry, 1'b0);
    chk("rst.err", u_if.Err, 1'b0);

    u_if.OutReady = 1'b1;
    op1("add",    ADD,    8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
    op1("sub0",   SUB,    8'h05, 8'h05, 8'h00, 1'b0, 1'b0);
    op1("subbw",  SUB,    8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op1("shrv3",  SHRV,   8'h81, 8'h03, 8'h10, 1'b0, 1'b0);
    op1("shlv1",  SHLV,   8'h81, 8'h01, 8'h02, 1'b1, 1'b0);
    op1("shlv0",  SHLV,   8'h81, 8'h00, 8'h81, 1'b0, 1'b0);
    op1("shrv0",  SHRV,   8'hA5, 8'h08, 8'hA5, 1'b0, 1'b0);
    op1("shrv7",  SHRV,   8'hC0, 8'h07, 8'h01, 1'b1, 1'b0);
    op1("shl",    SHL,    8'h81, 8'h00, 8'h02, 1'b1, 1'b0);
    op1("shr",    SHR,    8'h81, 8'h00, 8'h40, 1'b1, 1'b0);
    op1("cmp",    CMP,    8'h05, 8'h05, 8'h01, 1'b0, 1'b0);
    op1("cmpne",  CMP,    8'h05, 8'h06, 8'h00, 1'b0, 1'b0);
    op1("cmpls",  CMP_LS, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0);
    op1("cmpge",  CMP_LS, 8'h05, 8'h03, 8'h00, 1'b0, 1'b0);
    op1("and",    AND,    8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    op1("orr",    ORR,    8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0);
    op1("xorg",   XOR_G,  8'h07, 8'h00, 8'h01, 1'b0, 1'b0);
    op1("illeg",  5'd31,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);

`ifdef ALU_MUL_EN
    chk("mul.rdy", u_if.InReady, 1'b1);
    send(MUL, 8'h10, 8'h11);
    lat = 0;
    while (!u_if.OutValid && lat < 40) begin
      chk("mul.busyrdy", u_if.InReady, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk("mul.vld", u_if.OutValid, 1'b1);
    chk("mul.lat", lat, W + 1);
    chk("mul.out", u_if.Out, 8'h10);
    chk("mul.c",   u_if.Carry, 1'b1);
    chk("mul.err", u_if.Err, 1'b0);
    @(posedge clk); #1;
`else
    lat = 0;
    op1("mul", MUL, 8'h10, 8'h11, 8'h00, 1'b0, 1'b1);
`endif

    // Backpressure: result held, a competing request is ignored.
    u_if.OutReady = 1'b0;
    send(ADD, 8'h01, 8'h02);
    u_if.OP      = XOR_B;
    u_if.InputA  = 8'hAA;
    u_if.InputB  = 8'h55;
    u_if.InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.vld", u_if.OutValid, 1'b1);
      chk("bp.out", u_if.Out, 8'h03);
      chk("bp.c",   u_if.Carry, 1'b0);
      chk("bp.z",   u_if.Zero, 1'b0);
      chk("bp.rdy", u_if.InReady, 1'b0);
    end
    u_if.OutReady = 1'b1;
    #1;
    chk("b2b.rdy", u_if.InReady, 1'b1);
    @(posedge clk); #1;
    u_if.InValid = 1'b0;
    chk("b2b.vld", u_if.OutValid, 1'b1);
    chk("b2b.out", u_if.Out, 8'hFF);
    chk("b2b.z",   u_if.Zero, 1'b0);
    @(posedge clk); #1;
    chk("b2b.idle", u_if.OutValid, 1'b0);

    // Reset in the middle of an operation.
`ifdef ALU_MUL_EN
    send(MUL, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
`else
    u_if.OutReady = 1'b0;
    send(ADD, 8'hFF, 8'h02);
    #1 rst = 1'b1;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    u_if.OutReady = 1'b1;
    chk("mrst.vld", u_if.OutValid, 1'b0);
    chk("mrst.rdy", u_if.InReady, 1'b1);
    chk("mrst.z",   u_if.Zero, 1'b1);
    chk("mrst.out", u_if.Out, 8'h00);
    chk("mrst.c",   u_if.Carry, 1'b0);
    op1("radd", ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    // An abandoned product must never surface later.
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (u_if.OutValid) lat++;
    end
    chk("mrst.ghost", lat, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
